// File: rtl/timer_device.sv
// timer_device: memory-mapped programmable interval timer.
// Software loads PRESET and CTRL. The counter counts down from PRESET and
// raises a level interrupt request when it expires. The interrupt fires once
// (one-shot) or repeats (auto-reload).
// Build option: define TIMER_AUTORELOAD_EN to make MODE=01 behave as
// auto-reload. Without it, every MODE value behaves as one-shot, and the MODE
// bits are still kept as readable/writable storage.
module timer_device (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    // CTRL[3:0]: {IM, MODE[1:0], EN}
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PRESET = 2'd1;
    localparam logic [1:0] A_COUNT  = 2'd2;

    state_t      state;
    ctrl_t       ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic wr_ctrl;
    logic wr_preset;
    logic auto_reload;

    assign wr_ctrl   = we && (addr == A_CTRL);
    assign wr_preset = we && (addr == A_PRESET);

`ifdef TIMER_AUTORELOAD_EN
    assign auto_reload = (ctrl.mode == 2'b01);
`else
    assign auto_reload = 1'b0;
`endif

    // Countdown FSM plus the register file. Software writes are placed after
    // the hardware updates, so a CTRL write in the INT cycle overrides the
    // hardware EN clear. A CTRL/PRESET write also overrides a flag set in that
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctrl.en) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl.en) begin
                        state <= IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // A PRESET of 0 also ends up here, so it times out like a PRESET of 1.
                        count <= '0;
                        state <= INT;
                    end
                end
                INT: begin
                    if (auto_reload) begin
                        state <= LOAD;
                    end else begin
                        irq_flag <= 1'b1;
                        ctrl.en  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_ctrl) begin
                ctrl     <= ctrl_t'(wdata[3:0]);
                irq_flag <= 1'b0;
            end
            if (wr_preset) begin
                preset   <= wdata;
                irq_flag <= 1'b0;
            end
        end
    end

    // Level interrupt: the latched one-shot flag, or the INT cycle itself, gated by IM
    assign irq = ctrl.im & (irq_flag | (state == INT));

    // Combinational read mux
    always_comb begin
        rdata = '0;
        case (addr)
            A_CTRL:   rdata = {28'd0, ctrl};
            A_PRESET: rdata = preset;
            A_COUNT:  rdata = count;
            default:  rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_device.sv
// tb_timer_device: directed scenarios followed by random bus traffic. Every
// check compares the DUT against a behavioural model of the timer.
module tb_timer_device;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  addr  = 2'd0;
    logic        we    = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    timer_device dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state. Phase: 0 idle, 1 load, 2 counting, 3 expired.
    bit        m_en, m_im;
    bit [1:0]  m_mode;
    bit [31:0] m_preset, m_count;
    bit        m_flag;
    int        m_ph;

    function automatic bit m_auto();
`ifdef TIMER_AUTORELOAD_EN
        return m_mode == 2'b01;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [31:0] m_read(input bit [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_irq();
        return m_im && (m_flag || m_ph == 3);
    endfunction

    task automatic m_reset();
        m_en = 0; m_im = 0; m_mode = 0; m_preset = 0; m_count = 0; m_flag = 0; m_ph = 0;
    endtask

    task automatic m_step(input bit w, input bit [1:0] a, input bit [31:0] d);
        int nph;
        nph = m_ph;
        case (m_ph)
            0: if (m_en) nph = 1;
            1: begin m_count = m_preset; nph = 2; end
            2: begin
                if (!m_en) nph = 0;
                else if (m_count > 1) m_count = m_count - 1;
                else begin m_count = 0; nph = 3; end
            end
            default: begin
                if (m_auto()) nph = 1;
                else begin m_flag = 1; m_en = 0; nph = 0; end
            end
        endcase
        if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
        end
        if (w && a == 2'd1) begin
            m_preset = d; m_flag = 0;
        end
        m_ph = nph;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, clock edge, advance the model, then compare at the negedge.
    task automatic tick(input bit w, input bit [1:0] a, input bit [31:0] d);
        we = w; addr = a; wdata = d;
        @(posedge clk);
        m_step(w, a, d);
        @(negedge clk);
        we = 1'b0;
        chk("irq", {31'd0, irq}, {31'd0, m_irq()});
        chk("rdata", rdata, m_read(a));
    endtask

    task automatic rd_chk(input string tag, input bit [1:0] a, input bit [31:0] exp);
        addr = a; we = 1'b0;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        int hi;
        m_reset();

        // Reset values
        #12;
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'd0);
        rd_chk("rst_count", 2'd2, 32'd0);
        rst_n = 1'b1;

        // One-shot, PRESET=5: irq rises 7 cycles after the CTRL write and stays high
        tick(1, 2'd1, 32'd5);
        tick(1, 2'd0, 32'h9);
        for (int k = 1; k <= 7; k++) begin
            tick(0, 2'd2, 32'd0);
            chk("os_irq", {31'd0, irq}, (k == 7) ? 32'd1 : 32'd0);
            if (k >= 2) chk("os_cnt", rdata, 32'(7 - k));
        end
        tick(0, 2'd0, 32'd0);
        chk("os_ctrl", rdata, 32'h8);
        chk("os_hold", {31'd0, irq}, 32'd1);
        tick(1, 2'd0, 32'h8);
        chk("os_ack", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET=3: pulses every 5 cycles when enabled at build time
        tick(1, 2'd1, 32'd3);
        tick(1, 2'd0, 32'hB);
        hi = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(0, 2'd0, 32'd0);
            if (irq) hi++;
        end
`ifdef TIMER_AUTORELOAD_EN
        chk("ar_pulses", hi, 32'd4);
        chk("ar_en", rdata, 32'hB);
`else
        chk("ar_pulses", hi, 32'd16);
        chk("ar_en", rdata, 32'hA);
`endif
        tick(1, 2'd0, 32'd0);

        // Masked: irq never rises, COUNT reaches 0, EN clears
        tick(1, 2'd1, 32'd2);
        tick(1, 2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick(0, 2'd2, 32'd0);
            chk("mask_irq", {31'd0, irq}, 32'd0);
        end
        chk("mask_cnt", rdata, 32'd0);
        rd_chk("mask_ctrl", 2'd0, 32'd0);

        // Disable mid-count freezes COUNT; re-enable reloads it
        tick(1, 2'd1, 32'd10);
        tick(1, 2'd0, 32'h9);
        for (int k = 0; k < 3; k++) tick(0, 2'd2, 32'd0);
        tick(1, 2'd0, 32'h8);
        for (int k = 0; k < 4; k++) begin
            tick(0, 2'd2, 32'd0);
            chk("dis_cnt", rdata, 32'd8);
            chk("dis_irq", {31'd0, irq}, 32'd0);
        end
        tick(1, 2'd0, 32'h9);
        tick(0, 2'd2, 32'd0);
        tick(0, 2'd2, 32'd0);
        chk("reen_cnt", rdata, 32'd10);
        tick(1, 2'd0, 32'd0);

        // PRESET=0 times out like PRESET=1; COUNT and addr 3 ignore writes
        tick(1, 2'd1, 32'd0);
        tick(1, 2'd0, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            tick(0, 2'd2, 32'd0);
            chk("p0_irq", {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
        end
        tick(1, 2'd2, 32'h1234);
        chk("cnt_ro", rdata, 32'd0);
        tick(1, 2'd3, 32'hFFFF_FFFF);
        chk("a3_zero", rdata, 32'd0);
        tick(1, 2'd0, 32'd0);

        // Reset while irq is high drops it immediately
        tick(1, 2'd1, 32'd1);
        tick(1, 2'd0, 32'h9);
        for (int k = 0; k < 4; k++) tick(0, 2'd2, 32'd0);
        chk("pre_rst_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("mid_rst_irq", {31'd0, irq}, 32'd0);
        rd_chk("mid_rst_ctrl", 2'd0, 32'd0);
        rd_chk("mid_rst_preset", 2'd1, 32'd0);
        rd_chk("mid_rst_count", 2'd2, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random bus traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit        w;
            bit [1:0]  a;
            bit [31:0] d;
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1)
                d = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 6));
            else
                d = $urandom;
            tick(w, a, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
